// File: rtl/btn_pkg.sv
// Shared definitions for the button scan controller: FSM state encoding,
// default timing constants and a constant-width helper.
package btn_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_e;

    // 50 MHz system clock divided down to a 100 Hz sample tick
    localparam int CLK_DIV_100HZ = 500000;
    localparam int WIN_DEFAULT   = 4;

    // Ceiling log2, used to size counters from parameters
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running divider producing a one-cycle tick every CLK_DIV clocks.
// The first tick appears CLK_DIV cycles after reset is released.
module sample_tick_gen
    import btn_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_100HZ
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? clog2(CLK_DIV) : 1;

    logic [CW-1:0] div_cnt;

    // Count 0..CLK_DIV-1; tick is registered so it is high while the counter sits at 0
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else if (div_cnt == CW'(CLK_DIV - 1)) begin
            div_cnt <= '0;
            tick    <= 1'b1;
        end else begin
            div_cnt <= div_cnt + CW'(1);
            tick    <= 1'b0;
        end
    end

endmodule

// File: rtl/btn_scan_ctrl.sv
// Multi-button debounce controller. One shared window/hold-counter update
// path is time-multiplexed across the buttons, one button per clock after
// each sample tick.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for a sample tick (or a tick left pending by a scan)
//   SCAN    | updating button idx this cycle; last slot returns to IDLE,
//           | or restarts at slot 0 if another tick is already waiting
module btn_scan_ctrl
    import btn_pkg::*;
#(
    parameter int N_BTN        = 4,
    parameter int CLK_DIV      = CLK_DIV_100HZ,
    parameter int WIN          = WIN_DEFAULT,
    parameter int HOLD_TICKS   = 100,
    parameter int REPEAT_TICKS = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_n,
    output logic             tick,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long,
    output logic [N_BTN-1:0] btn_repeat,
    output logic             scan_busy
);

    localparam int IDX_W  = (N_BTN > 1) ? clog2(N_BTN) : 1;
    localparam int HC_MAX = HOLD_TICKS + REPEAT_TICKS;
    localparam int HC_W   = clog2(HC_MAX + 1);

    localparam logic [0:0] S_IDLE = ST_IDLE;
    localparam logic [0:0] S_SCAN = ST_SCAN;

    logic [N_BTN-1:0] sync_q1, sync_q2, pressed;
    logic [N_BTN-1:0] snap, snap_pend;
    logic             pending;
    logic [0:0]       state;
    logic [IDX_W-1:0] idx;
    logic             last_slot, scan_start;

    logic [WIN-1:0]   win      [N_BTN];
    logic [HC_W-1:0]  hold_cnt [N_BTN];

    logic [WIN-1:0]   win_nxt;
    logic             lvl_nxt;
    logic [HC_W-1:0]  cnt_inc;

    sample_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Two-flop synchronizer; resets to "released" so no phantom press follows reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= '1;
            sync_q2 <= '1;
        end else begin
            sync_q1 <= btn_n;
            sync_q2 <= sync_q1;
        end
    end

    assign pressed   = ~sync_q2;
    assign scan_busy = (state == S_SCAN);
    assign last_slot = (idx == IDX_W'(N_BTN - 1));
    assign scan_start = (tick || pending) &&
                        ((state == S_IDLE) || ((state == S_SCAN) && last_slot));

    // Scan sequencer; a tick landing mid-scan is parked with its own snapshot
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            pending   <= 1'b0;
            snap      <= '0;
            snap_pend <= '0;
        end else if (scan_start) begin
            state   <= S_SCAN;
            idx     <= '0;
            snap    <= pending ? snap_pend : pressed;
            pending <= pending && tick;
            if (tick) begin
                snap_pend <= pressed;
            end
        end else begin
            if (tick) begin
                pending   <= 1'b1;
                snap_pend <= pressed;
            end
            if (state == S_SCAN) begin
                if (last_slot) begin
                    state <= S_IDLE;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
        end
    end

    // Shared update path for the button currently addressed by idx
    always_comb begin
        win_nxt = {win[idx][WIN-2:0], snap[idx]};
        if (&win_nxt) begin
            lvl_nxt = 1'b1;
        end else if (~|win_nxt) begin
            lvl_nxt = 1'b0;
        end else begin
            lvl_nxt = btn_level[idx];
        end
        cnt_inc = (hold_cnt[idx] == HC_W'(HC_MAX)) ? hold_cnt[idx]
                                                  : hold_cnt[idx] + HC_W'(1);
    end

    // Per-button window, level, hold counter and one-cycle event pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_BTN; i++) begin
                win[i]      <= '0;
                hold_cnt[i] <= '0;
            end
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            btn_long    <= '0;
            btn_repeat  <= '0;
        end else begin
            btn_press   <= '0;
            btn_release <= '0;
            btn_long    <= '0;
            btn_repeat  <= '0;
            if (state == S_SCAN) begin
                win[idx]         <= win_nxt;
                btn_level[idx]   <= lvl_nxt;
                btn_press[idx]   <= lvl_nxt & ~btn_level[idx];
                btn_release[idx] <= ~lvl_nxt & btn_level[idx];
                if (!lvl_nxt) begin
                    hold_cnt[idx] <= '0;
                end else if (cnt_inc == HC_W'(HC_MAX)) begin
                    // reload so repeats keep coming every REPEAT_TICKS
                    hold_cnt[idx]   <= HC_W'(HOLD_TICKS);
                    btn_repeat[idx] <= 1'b1;
                end else begin
                    hold_cnt[idx] <= cnt_inc;
                    if (cnt_inc == HC_W'(HOLD_TICKS)) begin
                        btn_long[idx] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_btn_scan_ctrl.sv
// Bench for btn_scan_ctrl: directed button patterns, expected pulse events
// queued by the stimulus and consumed by an independent output monitor.
module tb_btn_scan_ctrl;

    logic       clk;
    logic       rst, rst_fast;
    logic [3:0] btn_n, btn_n_fast;

    logic       a_tick, a_busy;
    logic [3:0] a_level, a_press, a_rel, a_long, a_rep;
    logic       b_tick, b_busy;
    logic [3:0] b_level, b_press, b_rel, b_long, b_rep;

    int n_vec = 0;
    int n_err = 0;
    int cycle = 0;
    int last_tick = 0;
    logic b_done = 1'b0;

    typedef struct packed {
        logic [3:0] level;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] lng;
        logic [3:0] rpt;
        logic [7:0] lat;
    } ev_t;

    ev_t exp_q[$];

    btn_scan_ctrl #(.N_BTN(4), .CLK_DIV(8), .WIN(4), .HOLD_TICKS(5), .REPEAT_TICKS(2)) u_dut (
        .clk(clk), .rst(rst), .btn_n(btn_n), .tick(a_tick),
        .btn_level(a_level), .btn_press(a_press), .btn_release(a_rel),
        .btn_long(a_long), .btn_repeat(a_rep), .scan_busy(a_busy)
    );

    btn_scan_ctrl #(.N_BTN(4), .CLK_DIV(4), .WIN(4), .HOLD_TICKS(5), .REPEAT_TICKS(2)) u_dut_fast (
        .clk(clk), .rst(rst_fast), .btn_n(btn_n_fast), .tick(b_tick),
        .btn_level(b_level), .btn_press(b_press), .btn_release(b_rel),
        .btn_long(b_long), .btn_repeat(b_rep), .scan_busy(b_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cycle);
        end
    endtask

    function automatic void push_ev(input logic [3:0] lvl, input logic [3:0] prs,
                                    input logic [3:0] rl, input logic [3:0] lg,
                                    input logic [3:0] rp, input int lat);
        ev_t e;
        e.level = lvl;
        e.press = prs;
        e.rel   = rl;
        e.lng   = lg;
        e.rpt   = rp;
        e.lat   = 8'(lat);
        exp_q.push_back(e);
    endfunction

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!a_tick && n < 50);
        if (!a_tick) begin
            n_vec++;
            n_err++;
            $display("FAIL tick_timeout: no tick within %0d cycles (cycle %0d)", n, cycle);
        end
    endtask

    task automatic wait_ticks(input int k);
        int n;
        for (int i = 0; i < k; i++) wait_tick(n);
    endtask

    // Monitor: every cycle carrying a pulse is matched against the next queued event
    initial begin
        ev_t got, e;
        forever begin
            @(negedge clk);
            if (a_tick) last_tick = cycle;
            if (|{a_press, a_rel, a_long, a_rep}) begin
                got.level = a_level;
                got.press = a_press;
                got.rel   = a_rel;
                got.lng   = a_long;
                got.rpt   = a_rep;
                got.lat   = 8'(cycle - last_tick);
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_event: lvl=%b prs=%b rel=%b lng=%b rpt=%b lat=%0d (cycle %0d)",
                             got.level, got.press, got.rel, got.lng, got.rpt, got.lat, cycle);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        n_err++;
                        $display("FAIL event: got lvl=%b prs=%b rel=%b lng=%b rpt=%b lat=%0d, expected lvl=%b prs=%b rel=%b lng=%b rpt=%b lat=%0d (cycle %0d)",
                                 got.level, got.press, got.rel, got.lng, got.rpt, got.lat,
                                 e.level, e.press, e.rel, e.lng, e.rpt, e.lat, cycle);
                    end
                end
            end
        end
    end

    // Fast-divider instance: ticks outpace the idle gap, so scans must chain back-to-back
    initial begin
        int t, b, np, nr, nl, nq;
        rst_fast   = 1'b1;
        btn_n_fast = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_fast = 1'b0;
        t = 0; b = 0; np = 0; nr = 0; nl = 0; nq = 0;
        for (int k = 1; k <= 104; k++) begin
            @(negedge clk);
            if (k <= 100 && b_tick) t++;
            if (b_busy) b++;
            np += $countones(b_press);
            nr += $countones(b_rel);
            nl += $countones(b_long);
            nq += $countones(b_rep);
        end
        check("fast_tick_count", 64'(t), 64'd25);
        check("fast_scan_cycles", 64'(b), 64'd100);
        check("fast_scan_entries_vs_ticks", 64'(b / 4), 64'(t));
        check("fast_level", 64'(b_level), 64'hF);
        check("fast_press_pulses", 64'(np), 64'd4);
        check("fast_release_pulses", 64'(nr), 64'd0);
        check("fast_long_pulses", 64'(nl), 64'd4);
        check("fast_repeat_pulses", 64'(nq), 64'd32);
        b_done = 1'b1;
    end

    // Main stimulus for the 100 Hz-style instance (CLK_DIV=8)
    initial begin
        int n, busy_cnt;
        rst   = 1'b1;
        btn_n = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 64'({a_tick, a_level, a_press, a_rel, a_long, a_rep, a_busy}), 64'd0);
        rst = 1'b0;

        // all four pressed from reset: first tick, then levels after the 4th sample
        wait_tick(n);
        check("first_tick_delay", 64'(n), 64'd8);
        wait_ticks(2);
        repeat (6) @(negedge clk);
        check("no_level_before_4_ticks", 64'(a_level), 64'd0);
        wait_tick(n);
        for (int i = 0; i < 4; i++)
            push_ev(4'((1 << (i + 1)) - 1), 4'(1 << i), 4'h0, 4'h0, 4'h0, 2 + i);
        btn_n = 4'hF;
        wait_ticks(4);
        for (int i = 0; i < 4; i++)
            push_ev(4'(15 << (i + 1)), 4'h0, 4'(1 << i), 4'h0, 4'h0, 2 + i);

        // bounce on button 1: samples 1,0,1,1,1,1
        btn_n = 4'b1101;
        wait_tick(n);
        btn_n = 4'hF;
        wait_tick(n);
        btn_n = 4'b1101;
        wait_ticks(3);
        repeat (6) @(negedge clk);
        check("bounce_level_held_low", 64'(a_level), 64'd0);
        wait_tick(n);
        push_ev(4'b0010, 4'b0010, 4'h0, 4'h0, 4'h0, 3);
        btn_n = 4'hF;
        wait_ticks(4);
        push_ev(4'b0000, 4'h0, 4'b0010, 4'h0, 4'h0, 3);

        // long press on button 2, released after 12 held samples
        btn_n = 4'b1011;
        wait_ticks(4);
        push_ev(4'b0100, 4'b0100, 4'h0, 4'h0, 4'h0, 4);
        wait_ticks(4);
        push_ev(4'b0100, 4'h0, 4'h0, 4'b0100, 4'h0, 4);
        for (int r = 0; r < 3; r++) begin
            wait_ticks(2);
            push_ev(4'b0100, 4'h0, 4'h0, 4'h0, 4'b0100, 4);
        end
        wait_tick(n);
        btn_n = 4'hF;
        wait_tick(n);
        push_ev(4'b0100, 4'h0, 4'h0, 4'h0, 4'b0100, 4);
        wait_ticks(2);
        push_ev(4'b0100, 4'h0, 4'h0, 4'h0, 4'b0100, 4);
        wait_tick(n);
        push_ev(4'b0000, 4'h0, 4'b0100, 4'h0, 4'h0, 4);

        // latency of button 3 on the tick that completes its window
        btn_n = 4'b0111;
        wait_ticks(3);
        wait_tick(n);
        push_ev(4'b1000, 4'b1000, 4'h0, 4'h0, 4'h0, 5);
        btn_n = 4'hF;
        busy_cnt = 0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (a_busy) busy_cnt++;
            if (k == 4) check("level3_before_T5", 64'(a_level[3]), 64'd0);
            if (k == 5) check("level3_at_T5", 64'(a_level[3]), 64'd1);
        end
        check("scan_busy_cycles", 64'(busy_cnt), 64'd4);
        wait_ticks(4);
        push_ev(4'b0000, 4'h0, 4'b1000, 4'h0, 4'h0, 5);

        // reset asserted during the idx=2 slot
        btn_n = 4'h0;
        wait_ticks(4);
        push_ev(4'b0001, 4'b0001, 4'h0, 4'h0, 4'h0, 2);
        push_ev(4'b0011, 4'b0010, 4'h0, 4'h0, 4'h0, 3);
        repeat (3) @(negedge clk);
        check("busy_mid_scan", 64'(a_busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("reset_mid_scan", 64'({a_tick, a_level, a_press, a_rel, a_long, a_rep, a_busy}), 64'd0);
        rst = 1'b0;
        wait_tick(n);
        check("tick_after_midscan_reset", 64'(n), 64'd8);
        wait_ticks(2);
        repeat (6) @(negedge clk);
        check("windows_cleared_by_reset", 64'(a_level), 64'd0);
        wait_tick(n);
        for (int i = 0; i < 4; i++)
            push_ev(4'((1 << (i + 1)) - 1), 4'(1 << i), 4'h0, 4'h0, 4'h0, 2 + i);
        repeat (8) @(negedge clk);

        check("expected_events_left", 64'(exp_q.size()), 64'd0);
        for (int i = 0; i < 300 && !b_done; i++) @(negedge clk);
        check("fast_check_done", 64'(b_done), 64'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/btn_scan_ctrl.md
Name: btn_scan_ctrl

Overview:
Multi-button debounce controller: generates the ~100 Hz sample tick from the system clock and time-multiplexes one shared debounce-update datapath across N push buttons. Produces debounced levels plus one-cycle press, release, long-press and auto-repeat pulses for downstream FSMs (menus, counters, displays). Sits directly behind the board button pins and feeds user logic.

Parameters:
N_BTN, 4, number of buttons scanned
CLK_DIV, 500000, clk cycles per sample tick (50 MHz -> 100 Hz); must be >= N_BTN+2
WIN, 4, debounce window length in samples
HOLD_TICKS, 100, ticks a button stays down before btn_long fires (1 s)
REPEAT_TICKS, 20, ticks between btn_repeat pulses after btn_long

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
btn_n  in  N_BTN  raw asynchronous buttons, active-low (0 = pressed)
tick  out  1  one-cycle sample-tick strobe (debug/sharing)
btn_level  out  N_BTN  debounced level, 1 = pressed
btn_press  out  N_BTN  one-cycle pulse on level 0->1
btn_release  out  N_BTN  one-cycle pulse on level 1->0
btn_long  out  N_BTN  one-cycle pulse when held HOLD_TICKS ticks
btn_repeat  out  N_BTN  one-cycle pulse every REPEAT_TICKS ticks after btn_long
scan_busy  out  1  high while FSM is in SCAN

Behaviour:
- Single clock domain; clock and reset are one clk and a synchronous, active-high rst. All state updates on posedge clk; rst sampled only at posedge clk.
- Reset: all outputs 0, windows 0, hold counters 0, divider 0, FSM IDLE, pending flag 0. Reset asserted mid-scan aborts the scan; state is fully cleared on the next edge.
- Input sync: btn_n passes through a 2-FF synchronizer, then is inverted (pressed = 1) before sampling.
- Divider: counts 0..CLK_DIV-1; tick = 1 for the one cycle the counter wraps to 0. First tick comes CLK_DIV cycles after reset release.
- FSM states: IDLE, SCAN.
  - IDLE: on tick (or pending=1), idx <= 0, go SCAN, clear pending.
  - SCAN: processes button idx in this cycle. idx == N_BTN-1 -> IDLE, else idx+1.
  - A tick arriving while in SCAN sets pending; it is serviced immediately after return to IDLE. Not possible when CLK_DIV >= N_BTN+2, but must be handled.
- Per-button update (button i, in its SCAN cycle): win[i] <= {win[i][WIN-2:0], sample[i]}, using the synchronized value sampled at the tick, held in a snapshot register.
  - New window all ones -> level 1.
  - New window all zeros -> level 0.
  - Otherwise level holds (hysteresis).
- Latency: tick at cycle T. Button i is updated at edge T+1+i. btn_level[i] and its pulses are visible in cycle T+2+i. Each pulse is exactly one clk wide.
- Hold counter per button (sat. width $clog2(HOLD_TICKS+REPEAT_TICKS+1)), updated in the same SCAN slot:
  - level 0 after update -> counter 0.
  - level 1 -> counter+1.
  - btn_long when counter reaches HOLD_TICKS.
  - After btn_long, btn_repeat each time counter reaches HOLD_TICKS+REPEAT_TICKS. The counter then reloads to HOLD_TICKS, so repeat continues indefinitely.
- Press and long in the same slot are impossible (HOLD_TICKS >= 1). Release clears the counter with no further long/repeat. Simultaneous presses on several buttons yield pulses in consecutive cycles (slot order 0..N-1), never merged.

Decomposition:
- Shared package btn_pkg: FSM state enum (ST_IDLE, ST_SCAN), default constants for CLK_DIV_100HZ, WIN_DEFAULT, and function clog2.
- One sub-module: sample_tick_gen (parameter CLK_DIV; ports clk, rst, tick).
- Synchronizer, windows, counters and FSM stay in btn_scan_ctrl.

Test Plan:
Bench parameters: N_BTN=4, CLK_DIV=8, WIN=4, HOLD_TICKS=5, REPEAT_TICKS=2.
- Reset: hold rst 3 cycles with btn_n=4'b0000 -> all outputs 0. First tick 8 cycles after release. btn_level=4'b1111 only after 4 ticks, then btn_press pulses on bits 0,1,2,3 in 4 consecutive cycles.
- Bounce: btn_n[1] toggles 0,1,0,0,0,0 across ticks -> btn_level[1] rises only after 4 consecutive low samples. Exactly one btn_press[1], no btn_release[1] during the bounce.
- Long/repeat: hold btn_n[2]=0 for 12 ticks after level rises -> btn_long[2] at hold-count 5, then btn_repeat[2] at counts 7, 9, 11. Release -> one btn_release[2] after 4 high samples, no further repeats.
- Latency: single tick, btn_n[3] already stable low -> btn_level[3] changes in cycle T+2+3 = T+5 relative to tick cycle T. scan_busy is high for exactly 4 cycles.
- Reset mid-scan: assert rst in the cycle idx=2 -> next cycle all windows, levels and pulses are 0, FSM in IDLE, scan_busy=0.
- Pending tick: override with CLK_DIV=4 (< N_BTN+2) -> no tick lost. Scans run back-to-back, count of SCAN entries equals count of tick pulses over 100 cycles.
